request_queue: RTL

Bounded FIFO of memory requests that sits directly downstream of the trace parser and closes its handshake. It accepts parser requests, owns the simulation clock, and back-pressures the parser. Each request is retired after a fixed service time at the head of the queue. It supplies `queue_time`, `queue_full` and `pending_request`, and emits a one-cycle retire pulse per request toward the DRAM command stage.

---
 rtl/global_defs.sv | 31 +++
 rtl/request_queue_if.sv | 26 ++
 rtl/queue_fifo.sv | 59 +++++
 rtl/request_queue.sv | 93 +++++++++
 4 files changed

// File: rtl/global_defs.sv
// Shared types for the trace-driven memory model: parser requests, queue entries
// and default sizing for the request queue.
package global_defs;

  localparam int ADDRESS_WIDTH          = 32;
  localparam int QUEUE_DEPTH_DEFAULT    = 16;
  localparam int SERVICE_CYCLES_DEFAULT = 4;

  typedef logic [31:0] int_t;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } parsed_op_t;

  typedef struct packed {
    parsed_op_t               opcode;
    logic [ADDRESS_WIDTH-1:0] address;
    int_t                     time_cpu;
    logic                     op_ready_s;
  } parser_out_struct_t;

  typedef struct packed {
    parsed_op_t               opcode;
    logic [ADDRESS_WIDTH-1:0] address;
    int_t                     time_cpu;
    int_t                     time_in;
  } queue_entry_t;

endpackage

// File: rtl/request_queue_if.sv
// Bundle between the trace parser / DRAM command stage (master) and the request queue (slave).
interface request_queue_if
  import global_defs::*;
#(
  parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEFAULT
) ();

  parser_out_struct_t            in;
  int_t                          queue_time;
  logic                          queue_full;
  logic                          pending_request;
  logic [$clog2(QUEUE_DEPTH):0]  queue_count;
  logic                          retire_valid;
  queue_entry_t                  retire_entry;

  modport slave (
    input  in,
    output queue_time, queue_full, pending_request, queue_count, retire_valid, retire_entry
  );

  modport master (
    output in,
    input  queue_time, queue_full, pending_request, queue_count, retire_valid, retire_entry
  );

endinterface

// File: rtl/queue_fifo.sv
// Circular buffer of queue entries: storage, head/tail pointers and occupancy count.
// Callers must not push when full nor pop when empty.
module queue_fifo
  import global_defs::*;
#(
  parameter int DEPTH = QUEUE_DEPTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  queue_entry_t              push_entry,
  input  logic                      pop,
  output queue_entry_t              head_entry,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  queue_entry_t           mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_reg;
  logic [PTR_W-1:0]       rd_ptr_reg;
  logic [CNT_W-1:0]       count_reg;

  // Storage carries no reset; stale contents are never visible because count gates reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_entry = mem[rd_ptr_reg];
  assign count      = count_reg;
  assign full       = (count_reg == CNT_W'(DEPTH));
  assign empty      = (count_reg == '0);

endmodule

// File: rtl/request_queue.sv
// Bounded request FIFO closing the parser handshake; owns simulation time and retires
// the head after a fixed service time. REQUEST_QUEUE_TIME_SKIP_EN enables idle time skips.
module request_queue
  import global_defs::*;
#(
  parameter int QUEUE_DEPTH    = QUEUE_DEPTH_DEFAULT,
  parameter int SERVICE_CYCLES = SERVICE_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  request_queue_if.slave  q
);

  localparam int                TIMER_W    = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SERVICE_CYCLES - 1);

  int_t                          queue_time_reg;
  int_t                          queue_time_next;
  logic [TIMER_W-1:0]            head_timer_reg;
  logic [TIMER_W-1:0]            head_timer_next;
  logic                          pending_reg;

  logic                          push;
  logic                          pop;
  logic                          full;
  logic                          empty;
  logic [$clog2(QUEUE_DEPTH):0]  count;
  queue_entry_t                  push_entry;
  queue_entry_t                  head_entry;

  // Full blocks a push even when the head retires on the same edge.
  assign push = q.in.op_ready_s && !full && (q.in.time_cpu <= queue_time_reg);
  assign pop  = !empty && (head_timer_reg == TIMER_LAST);

  always_comb begin
    push_entry          = '0;
    push_entry.opcode   = q.in.opcode;
    push_entry.address  = q.in.address;
    push_entry.time_cpu = q.in.time_cpu;
    push_entry.time_in  = queue_time_reg;
  end

  always_comb begin
    queue_time_next = queue_time_reg + 32'd1;
`ifdef REQUEST_QUEUE_TIME_SKIP_EN
    // Nothing to service and the parser is waiting on the future: jump straight there.
    if (empty && !push && q.in.op_ready_s && (q.in.time_cpu > queue_time_reg + 32'd1)) begin
      queue_time_next = q.in.time_cpu;
    end
`endif
  end

  always_comb begin
    head_timer_next = head_timer_reg + TIMER_W'(1);
    if (empty || pop) begin
      head_timer_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      queue_time_reg <= '0;
      head_timer_reg <= '0;
      pending_reg    <= 1'b0;
    end else begin
      queue_time_reg <= queue_time_next;
      head_timer_reg <= head_timer_next;
      pending_reg    <= q.in.op_ready_s && !push;
    end
  end

  queue_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  assign q.queue_time      = queue_time_reg;
  assign q.queue_full      = full;
  assign q.pending_request = pending_reg;
  assign q.queue_count     = count;
  assign q.retire_valid    = pop;
  assign q.retire_entry    = head_entry;

endmodule
